cam_stream_gen: RTL and testbench

CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

---
 rtl/cam_stream_gen.sv | 191 +++++++++++++++++++
 tb/tb_cam_stream_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_stream_gen.sv
// Camera-style RGB444 stream generator: VSYNC/HREF timing with an orange blob on a blue-grey background.
// Build macro CAM_STREAM_NOISE_EN adds LFSR noise on the low bits of the background blue channel.
module cam_stream_gen #(
  parameter int H_ACTIVE    = 320,
  parameter int H_BLANK     = 64,
  parameter int V_ACTIVE    = 240,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [8:0] blob_x0,
  input  logic [8:0] blob_x1,
  input  logic [8:0] blob_y0,
  input  logic [8:0] blob_y1,
  output logic       vsync,
  output logic       HREF,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       frame_start,
  output logic       busy
);

  localparam int L     = H_ACTIVE + H_BLANK;
  localparam int XW    = (L > 1) ? $clog2(L) : 1;
  localparam int MAX_A = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int MAX_B = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAX_L = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int LW    = $clog2(MAX_L + 1);
  localparam int YW    = $clog2(V_ACTIVE + 1);

  typedef enum logic [2:0] {IDLE, SYNC, BACK, ACTIVE, FRONT} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [LW-1:0] line_q, line_d;
  logic [YW-1:0] y_q, y_d;
  logic [8:0]    sx0_q, sx0_d, sx1_q, sx1_d, sy0_q, sy0_d, sy1_q, sy1_d;
  logic          vsync_q, vsync_d, href_q, href_d, fs_q, fs_d, busy_q, busy_d;
  logic [11:0]   rgb_q, rgb_d;
  logic [LW-1:0] last_line;
  logic          line_end, in_blob;
  logic [15:0]   x_ext, y_ext;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    line_d    = line_q;
    y_d       = y_q;
    fs_d      = 1'b0;
    sx0_d     = sx0_q;
    sx1_d     = sx1_q;
    sy0_d     = sy0_q;
    sy1_d     = sy1_q;
    line_end  = (x_q == XW'(L - 1));
    last_line = '0;
    case (state_q)
      SYNC:    last_line = LW'(VSYNC_LINES - 1);
      BACK:    last_line = LW'(V_BACK - 1);
      ACTIVE:  last_line = LW'(V_ACTIVE - 1);
      FRONT:   last_line = LW'(V_FRONT - 1);
      default: last_line = '0;
    endcase

    if (state_q == IDLE) begin
      if (enable) begin
        state_d = SYNC;
        x_d     = '0;
        line_d  = '0;
        fs_d    = 1'b1;
      end
    end else begin
      x_d = line_end ? '0 : x_q + 1'b1;
      if (line_end) begin
        if (state_q == ACTIVE) begin
          y_d = (y_q == YW'(V_ACTIVE - 1)) ? '0 : y_q + 1'b1;
        end
        if (line_q == last_line) begin
          line_d = '0;
          case (state_q)
            SYNC:   state_d = BACK;
            BACK:   state_d = ACTIVE;
            ACTIVE: state_d = FRONT;
            FRONT: begin
              // A frame always runs to the end of FRONT; enable only decides whether another follows.
              if (enable) begin
                state_d = SYNC;
                fs_d    = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end
            default: state_d = IDLE;
          endcase
        end else begin
          line_d = line_q + 1'b1;
        end
      end
    end

    if (fs_d) begin
      sx0_d = blob_x0;
      sx1_d = blob_x1;
      sy0_d = blob_y0;
      sy1_d = blob_y1;
    end
  end

`ifdef CAM_STREAM_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (href_d) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  // Outputs are computed from the next-state values so the registered pixel lands with its HREF.
  always_comb begin
    x_ext   = 16'(x_d);
    y_ext   = 16'(y_d);
    vsync_d = (state_d == SYNC);
    busy_d  = (state_d != IDLE);
    href_d  = (state_d == ACTIVE) && (x_d < XW'(H_ACTIVE));
    in_blob = (x_ext >= 16'(sx0_q)) && (x_ext < 16'(sx1_q)) &&
              (y_ext >= 16'(sy0_q)) && (y_ext < 16'(sy1_q));
    rgb_d   = 12'h000;
    if (href_d) begin
      rgb_d = in_blob ? 12'hF80 : 12'h22A;
`ifdef CAM_STREAM_NOISE_EN
      if (!in_blob) begin
        rgb_d[1:0] = rgb_d[1:0] ^ lfsr_q[1:0];
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      line_q  <= '0;
      y_q     <= '0;
      sx0_q   <= '0;
      sx1_q   <= '0;
      sy0_q   <= '0;
      sy1_q   <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      line_q  <= line_d;
      y_q     <= y_d;
      sx0_q   <= sx0_d;
      sx1_q   <= sx1_d;
      sy0_q   <= sy0_d;
      sy1_q   <= sy1_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      rgb_q   <= rgb_d;
    end
  end

  assign vsync       = vsync_q;
  assign HREF        = href_q;
  assign red         = rgb_q[11:8];
  assign green       = rgb_q[7:4];
  assign blue        = rgb_q[3:0];
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Self-checking bench for cam_stream_gen on a reduced frame geometry, against an arithmetic frame model.
module tb_cam_stream_gen;
  localparam int HA   = 16;
  localparam int HB   = 4;
  localparam int VA   = 12;
  localparam int VS   = 2;
  localparam int VB   = 2;
  localparam int VF   = 2;
  localparam int L    = HA + HB;
  localparam int FL   = L * (VS + VB + VA + VF);
  localparam int ACT0 = (VS + VB) * L;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [8:0] bx0, bx1, by0, by1;
  logic       vsync, HREF, frame_start, busy;
  logic [3:0] red, green, blue;

  int checks = 0;
  int errors = 0;
  logic [15:0] obs [FL];
  logic [8:0]  cx0 = 9'd0, cx1 = 9'd0, cy0 = 9'd0, cy1 = 9'd0;

  cam_stream_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .blob_x0(bx0), .blob_x1(bx1), .blob_y0(by0), .blob_y1(by1),
    .vsync(vsync), .HREF(HREF), .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected {frame_start, busy, vsync, HREF, rgb} for cycle t of a frame, t=0 being the frame_start cycle.
  function automatic logic [15:0] expect_word(int t, int x0, int x1, int y0, int y1);
    int line, col, row;
    logic act, org;
    logic [11:0] rgb;
    line = t / L;
    col  = t % L;
    row  = line - VS - VB;
    act  = (row >= 0) && (row < VA) && (col < HA);
    org  = act && (col >= x0) && (col < x1) && (row >= y0) && (row < y1);
    rgb  = 12'h000;
    if (org) rgb = 12'hF80;
    else if (act) rgb = 12'h22A;
    return {(t == 0), 1'b1, (line < VS), act, rgb};
  endfunction

  function automatic logic [15:0] care_mask(logic [15:0] exp_w);
    logic [15:0] m;
    m = 16'hFFFF;
`ifdef CAM_STREAM_NOISE_EN
    if (exp_w[12] && exp_w[11:0] == 12'h22A) m = 16'hFFFC;
`else
    if (exp_w[12] === 1'bx) m = 16'h0000;
`endif
    return m;
  endfunction

  function automatic int exp_orange(int x0, int x1, int y0, int y1);
    int w, h;
    w = ((x1 < HA) ? x1 : HA) - x0;
    h = ((y1 < VA) ? y1 : VA) - y0;
    if (w < 0) w = 0;
    if (h < 0) h = 0;
    return w * h;
  endfunction

  task automatic capture_frame(input int change_t, input logic [8:0] n0, input logic [8:0] n1,
                               input logic [8:0] n2, input logic [8:0] n3, input int drop_t);
    for (int t = 0; t < FL; t++) begin
      obs[t] = {frame_start, busy, vsync, HREF, red, green, blue};
      if (t == change_t) begin
        bx0 = n0; bx1 = n1; by0 = n2; by1 = n3;
      end
      if (t == drop_t) enable = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic scan_frame(input int x0, input int x1, input int y0, input int y1,
                            output int bad, output int first);
    logic [15:0] e;
    bad = 0;
    first = 0;
    for (int t = 0; t < FL; t++) begin
      e = expect_word(t, x0, x1, y0, y1);
      if (((obs[t] ^ e) & care_mask(e)) !== 16'h0000) begin
        if (bad == 0) first = t;
        bad++;
      end
    end
  endtask

  task automatic wait_frame_start(output bit ok);
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 2 * FL) begin
      @(negedge clk);
      n++;
    end
    ok = (frame_start === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    bx0 = 9'd0; bx1 = 9'd0; by0 = 9'd0; by1 = 9'd0;
    repeat (3) @(negedge clk);
    checks++; if (vsync !== 1'b0) begin errors++; $display("[TB] FAIL reset_vsync got=%b want=0", vsync); end
    checks++; if (HREF !== 1'b0) begin errors++; $display("[TB] FAIL reset_href got=%b want=0", HREF); end
    checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("[TB] FAIL reset_rgb got=%h want=000", {red, green, blue}); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_fs got=%b want=0", frame_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, frame_start} !== 2'b00) begin errors++; $display("[TB] FAIL idle_hold got busy,fs=%b want=00", {busy, frame_start}); end
  endtask

  task automatic test_first_frame_start();
    cx0 = 9'd5; cx1 = 9'd10; cy0 = 9'd3; cy1 = 9'd7;
    bx0 = cx0; bx1 = cx1; by0 = cy0; by1 = cy1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    checks++; if ({frame_start, vsync, busy} !== 3'b111) begin errors++; $display("[TB] FAIL first_fs got fs,vs,busy=%b want=111", {frame_start, vsync, busy}); end
  endtask

  task automatic test_frame_timing();
    int bad, first, org, first_org, vs_cnt, bursts, burst_bad, run, last_fall;
    logic prev;
    capture_frame(-1, cx0, cx1, cy0, cy1, -1);
    scan_frame(cx0, cx1, cy0, cy1, bad, first);
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL timing_frame bad=%0d first t=%0d got=%h want=%h", bad, first, obs[first], expect_word(first, cx0, cx1, cy0, cy1)); end
    org = 0; first_org = -1; vs_cnt = 0; bursts = 0; burst_bad = 0; run = 0; last_fall = -1; prev = 1'b0;
    for (int t = 0; t < FL; t++) begin
      if (obs[t][12] && obs[t][11:0] == 12'hF80) begin
        if (first_org < 0) first_org = t;
        org++;
      end
      if (obs[t][13]) vs_cnt++;
      if (obs[t][12]) begin
        if (!prev) begin
          bursts++;
          if (last_fall >= 0 && t - last_fall != HB) burst_bad++;
        end
        run++;
      end else if (prev) begin
        if (run != HA) burst_bad++;
        run = 0;
        last_fall = t;
      end
      prev = obs[t][12];
    end
    checks++; if (org !== exp_orange(cx0, cx1, cy0, cy1)) begin errors++; $display("[TB] FAIL orange_count got=%0d want=%0d", org, exp_orange(cx0, cx1, cy0, cy1)); end
    checks++; if (first_org !== ACT0 + 3 * L + 5) begin errors++; $display("[TB] FAIL first_orange got t=%0d want t=%0d", first_org, ACT0 + 3 * L + 5); end
    checks++; if (vs_cnt !== VS * L) begin errors++; $display("[TB] FAIL vsync_len got=%0d want=%0d", vs_cnt, VS * L); end
    checks++; if (bursts !== VA) begin errors++; $display("[TB] FAIL href_bursts got=%0d want=%0d", bursts, VA); end
    checks++; if (burst_bad !== 0) begin errors++; $display("[TB] FAIL href_shape got=%0d bad bursts/gaps want=0", burst_bad); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL frame_period got fs=%b at t=%0d want=1", frame_start, FL); end
  endtask

  task automatic test_random_blobs();
    int bad, first, org;
    logic [8:0] n0, n1, n2, n3;
    for (int i = 0; i < 5; i++) begin
      n0 = 9'($urandom_range(0, 24)); n1 = 9'($urandom_range(0, 24));
      n2 = 9'($urandom_range(0, 16)); n3 = 9'($urandom_range(0, 16));
      if (i == 0) begin n0 = 9'd8; n1 = 9'd8; end
      if (i == 1) begin n2 = 9'd9; n3 = 9'd4; end
      if (i == 2) begin n0 = 9'd0; n1 = 9'd300; n2 = 9'd0; n3 = 9'd300; end
      capture_frame(ACT0 + (VA / 2) * L + 3, n0, n1, n2, n3, -1);
      scan_frame(cx0, cx1, cy0, cy1, bad, first);
      checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL blob_frame%0d bad=%0d first t=%0d got=%h want=%h", i, bad, first, obs[first], expect_word(first, cx0, cx1, cy0, cy1)); end
      org = 0;
      for (int t = 0; t < FL; t++) if (obs[t][12] && obs[t][11:0] == 12'hF80) org++;
      checks++; if (org !== exp_orange(cx0, cx1, cy0, cy1)) begin errors++; $display("[TB] FAIL blob_orange%0d got=%0d want=%0d", i, org, exp_orange(cx0, cx1, cy0, cy1)); end
      cx0 = n0; cx1 = n1; cy0 = n2; cy1 = n3;
    end
  endtask

  task automatic test_enable_drop();
    int bad, first, stray;
    capture_frame(-1, cx0, cx1, cy0, cy1, ACT0 + 5 * L + 2);
    scan_frame(cx0, cx1, cy0, cy1, bad, first);
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL drop_frame bad=%0d first t=%0d got=%h want=%h", bad, first, obs[first], expect_word(first, cx0, cx1, cy0, cy1)); end
    checks++; if ({busy, frame_start} !== 2'b00) begin errors++; $display("[TB] FAIL drop_idle got busy,fs=%b want=00", {busy, frame_start}); end
    stray = 0;
    for (int t = 0; t < 2 * FL; t++) begin
      if (busy !== 1'b0 || frame_start !== 1'b0) stray++;
      @(negedge clk);
    end
    checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL drop_stays_idle got=%0d active cycles want=0", stray); end
  endtask

  task automatic test_reset_mid_href();
    bit ok;
    int n, bad, first;
    enable = 1'b1;
    wait_frame_start(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL restart_fs got=timeout want=frame_start"); end
    n = 0;
    while (HREF !== 1'b1 && n < 2 * FL) begin @(negedge clk); n++; end
    checks++; if (HREF !== 1'b1) begin errors++; $display("[TB] FAIL href_seen got=%b want=1", HREF); end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({frame_start, busy, vsync, HREF, red, green, blue} !== 16'h0000) begin errors++; $display("[TB] FAIL async_reset got=%h want=0000", {frame_start, busy, vsync, HREF, red, green, blue}); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({frame_start, vsync} !== 2'b11) begin errors++; $display("[TB] FAIL post_reset_fs got fs,vs=%b want=11", {frame_start, vsync}); end
    capture_frame(-1, cx0, cx1, cy0, cy1, -1);
    scan_frame(cx0, cx1, cy0, cy1, bad, first);
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL post_reset_frame bad=%0d first t=%0d got=%h want=%h", bad, first, obs[first], expect_word(first, cx0, cx1, cy0, cy1)); end
  endtask

`ifdef CAM_STREAM_NOISE_EN
  task automatic test_noise_repeat();
    logic [15:0] first_run [FL];
    bit ok;
    int diff, varied;
    for (int run = 0; run < 2; run++) begin
      reset = 1'b1; enable = 1'b0;
      @(negedge clk);
      reset = 1'b0; enable = 1'b1;
      wait_frame_start(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL noise_fs%0d got=timeout want=frame_start", run); end
      capture_frame(-1, cx0, cx1, cy0, cy1, -1);
      if (run == 0) for (int t = 0; t < FL; t++) first_run[t] = obs[t];
    end
    diff = 0; varied = 0;
    for (int t = 0; t < FL; t++) begin
      if (obs[t] !== first_run[t]) diff++;
      if (obs[t][12] && obs[t][11:2] == 10'b0010001010 && obs[t][1:0] != 2'b10) varied++;
    end
    checks++; if (diff !== 0) begin errors++; $display("[TB] FAIL noise_repeat got=%0d differing cycles want=0", diff); end
    checks++; if (varied == 0) begin errors++; $display("[TB] FAIL noise_varies got=%0d varied pixels want>0", varied); end
  endtask
`endif

  initial begin
    #(100 * FL * 10);
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_first_frame_start();
    test_frame_timing();
    test_random_blobs();
    test_enable_drop();
    test_reset_mid_href();
`ifdef CAM_STREAM_NOISE_EN
    test_noise_repeat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
